// File: rtl/nq_multiplier_axi4s_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package  : nq_mul_pkg
// Brief    : Shared types and the round/saturate helper for the N.Q multiplier.
// Revision : 1.0
// ============================================================================
package nq_mul_pkg;

    // Widest operand the helper supports; products are carried at twice this.
    localparam int NQ_MAX_N  = 64;
    localparam int NQ_PROD_W = 2 * NQ_MAX_N;

    typedef enum logic [0:0] {
        ST_A = 1'b0,
        ST_B = 1'b1
    } beat_state_t;

    typedef struct packed {
        logic                ovf;
        logic [NQ_MAX_N-1:0] data;
    } nq_res_t;

    function automatic nq_res_t sat_round_nq(
        input logic signed [NQ_PROD_W-1:0] p,
        input int                          n_bits,
        input int                          q_bits,
        input logic                        round_en,
        input logic                        sat_en
    );
        logic signed [NQ_PROD_W-1:0] r;
        logic signed [NQ_PROD_W-1:0] hi;
        logic signed [NQ_PROD_W-1:0] lim;
        nq_res_t                     res;
        r = p;
        if (round_en) begin
            r = r + (NQ_PROD_W'(1) << (q_bits - 1));
        end
        r       = r >>> q_bits;
        hi      = r >>> (n_bits - 1);
        res.ovf = !((hi == '0) || (hi == '1));
        lim     = (NQ_PROD_W'(1) << (n_bits - 1)) - NQ_PROD_W'(1);
        if (r[NQ_PROD_W-1]) begin
            lim = ~lim;
        end
        res.data = (sat_en && res.ovf) ? lim[NQ_MAX_N-1:0] : r[NQ_MAX_N-1:0];
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nq_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : nq_result_fifo
// Brief    : Synchronous FIFO with a registered head; count includes the head.
// Revision : 1.0
// ============================================================================
module nq_result_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_mem_cnt;
    logic             r_out_vld;
    logic [WIDTH-1:0] r_out_data;

    logic w_load;
    logic w_from_mem;
    logic w_bypass;
    logic w_mem_wr;

    // The head register refills from memory first; a write goes straight to
    // the head only when memory is empty, which keeps issue order intact.
    assign w_load     = !r_out_vld || rd_ready;
    assign w_from_mem = w_load && (r_mem_cnt != '0);
    assign w_bypass   = w_load && (r_mem_cnt == '0) && wr_en;
    assign w_mem_wr   = wr_en && !w_bypass;

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_from_mem) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_mem_wr, w_from_mem})
                2'b10:   r_mem_cnt <= r_mem_cnt + CW'(1);
                2'b01:   r_mem_cnt <= r_mem_cnt - CW'(1);
                default: r_mem_cnt <= r_mem_cnt;
            endcase
            if (w_load) begin
                r_out_vld <= w_from_mem || w_bypass;
                if (w_from_mem) begin
                    r_out_data <= r_mem[r_rd_ptr];
                end else if (w_bypass) begin
                    r_out_data <= wr_data;
                end
            end
        end
    end

    assign rd_valid = r_out_vld;
    assign rd_data  = r_out_data;
    assign count    = r_mem_cnt + CW'(r_out_vld);

endmodule
`default_nettype wire

// File: rtl/nq_multiplier_axi4s_pipe.sv
`default_nettype none
// ============================================================================
// Module   : nq_multiplier_axi4s_pipe
// Brief    : Pipelined signed N.Q multiplier behind AXI4-S, credit-gated
//            ingress and a result FIFO absorbing egress backpressure.
// Revision : 1.0
// ============================================================================
module nq_multiplier_axi4s_pipe
    import nq_mul_pkg::*;
#(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int N_BITS_P         = 32,
    parameter int Q_BITS_P         = 15,
    parameter int PIPE_STAGES_P    = 3,
    parameter int FIFO_DEPTH_P     = 8,
    parameter int ROUND_P          = 0,
    parameter int SATURATE_P       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ing_tvalid,
    output logic                        ing_tready,
    input  logic [AXI_DATA_WIDTH_P-1:0] ing_tdata,
    input  logic                        ing_tlast,
    input  logic [AXI_ID_WIDTH_P-1:0]   ing_tid,
    output logic                        egr_tvalid,
    input  logic                        egr_tready,
    output logic [AXI_DATA_WIDTH_P-1:0] egr_tdata,
    output logic                        egr_tlast,
    output logic [AXI_ID_WIDTH_P-1:0]   egr_tid,
    output logic                        egr_tuser,
    output logic                        protocol_err
);

    localparam int PROD_W = 2 * N_BITS_P;
    localparam int OCC_W  = $clog2(FIFO_DEPTH_P + 1);

    typedef struct packed {
        logic [AXI_ID_WIDTH_P-1:0]   tid;
        logic                        tuser;
        logic [AXI_DATA_WIDTH_P-1:0] data;
    } entry_t;

    beat_state_t               r_state;
    beat_state_t               w_state_nxt;
    logic [N_BITS_P-1:0]       r_a;
    logic [AXI_ID_WIDTH_P-1:0] r_tid;
    logic                      r_err;
    logic                      w_ing_hs;
    logic                      w_issue;
    logic                      w_latch;
    logic                      w_err;

    logic [N_BITS_P-1:0]        w_b;
    logic signed [PROD_W-1:0]   w_prod;
    logic [PIPE_STAGES_P-1:0]   r_vld;
    logic signed [PROD_W-1:0]   r_prod [PIPE_STAGES_P];
    logic [AXI_ID_WIDTH_P-1:0]  r_ptid [PIPE_STAGES_P];

    nq_res_t                    w_res;
    entry_t                     w_wr_entry;
    entry_t                     w_rd_entry;
    logic                       w_rd_valid;
    logic [OCC_W-1:0]           w_fifo_cnt;
    logic [OCC_W-1:0]           w_in_flight;
    logic [OCC_W-1:0]           w_occ;

    // Credit: every pair in the pipeline already owns a FIFO slot.
    always_comb begin
        w_in_flight = '0;
        for (int i = 0; i < PIPE_STAGES_P; i++) begin
            w_in_flight = w_in_flight + OCC_W'(r_vld[i]);
        end
    end

    assign w_occ      = w_in_flight + w_fifo_cnt;
    assign ing_tready = !rst && (w_occ < OCC_W'(FIFO_DEPTH_P));
    assign w_ing_hs   = ing_tvalid && ing_tready;

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_latch     = 1'b0;
        w_err       = 1'b0;
        if (w_ing_hs) begin
            case (r_state)
                ST_A: begin
                    if (!ing_tlast) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_B;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_B: begin
                    if (!ing_tlast) begin
                        w_latch = 1'b1;
                        w_err   = 1'b1;
                    end else begin
                        w_issue     = 1'b1;
                        w_err       = (ing_tid != r_tid);
                        w_state_nxt = ST_A;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_A;
            r_a     <= '0;
            r_tid   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err;
            if (w_latch) begin
                r_a   <= ing_tdata[N_BITS_P-1:0];
                r_tid <= ing_tid;
            end
        end
    end

    assign w_b    = ing_tdata[N_BITS_P-1:0];
    assign w_prod = $signed({{N_BITS_P{r_a[N_BITS_P-1]}}, r_a})
                  * $signed({{N_BITS_P{w_b[N_BITS_P-1]}}, w_b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < PIPE_STAGES_P; i++) begin
                r_prod[i] <= '0;
                r_ptid[i] <= '0;
            end
        end else begin
            r_vld[0]  <= w_issue;
            r_prod[0] <= w_prod;
            r_ptid[0] <= r_tid;
            for (int i = 1; i < PIPE_STAGES_P; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_prod[i] <= r_prod[i-1];
                r_ptid[i] <= r_ptid[i-1];
            end
        end
    end

    assign w_res = sat_round_nq(NQ_PROD_W'(r_prod[PIPE_STAGES_P-1]), N_BITS_P, Q_BITS_P,
                                ROUND_P != 0, SATURATE_P != 0);

    assign w_wr_entry.tid   = r_ptid[PIPE_STAGES_P-1];
    assign w_wr_entry.tuser = w_res.ovf;
    assign w_wr_entry.data  = AXI_DATA_WIDTH_P'($signed(w_res.data[N_BITS_P-1:0]));

    nq_result_fifo #(
        .WIDTH (AXI_ID_WIDTH_P + 1 + AXI_DATA_WIDTH_P),
        .DEPTH (FIFO_DEPTH_P)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (r_vld[PIPE_STAGES_P-1]),
        .wr_data  (w_wr_entry),
        .rd_ready (egr_tready),
        .rd_valid (w_rd_valid),
        .rd_data  (w_rd_entry),
        .count    (w_fifo_cnt)
    );

    if (N_BITS_P < NQ_MAX_N) begin : g_unused_res
        logic w_unused_res;
        assign w_unused_res = ^w_res.data[NQ_MAX_N-1:N_BITS_P];
    end

    if (AXI_DATA_WIDTH_P > N_BITS_P) begin : g_unused_tdata
        logic w_unused_tdata;
        assign w_unused_tdata = ^ing_tdata[AXI_DATA_WIDTH_P-1:N_BITS_P];
    end

    assign egr_tvalid   = w_rd_valid;
    assign egr_tdata    = w_rd_entry.data;
    assign egr_tid      = w_rd_entry.tid;
    assign egr_tuser    = w_rd_entry.tuser;
    assign egr_tlast    = 1'b1;
    assign protocol_err = r_err;

endmodule
`default_nettype wire
